// File: rtl/uc_multicycle.sv
// Multicycle instruction control unit: IDLE/DECODE/EXEC/MEM/WB sequencer driving ALU, register file and memory strobes.
// Define UC_MEM_TIMEOUT_EN to abandon memory accesses whose ack never arrives (bus_err_o pulse); otherwise MEM waits forever.
module uc_multicycle #(
   parameter int INSTR_W     = 16,
   parameter int OPC_W       = 4,
   parameter int RA_W        = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic               instr_vld_i,
   output logic               instr_rdy_o,
   input  logic               zero_i,
   input  logic               ack_i,
   output logic               stb_o,
   output logic               mem_we_o,
   output logic [2:0]         alu_control_o,
   output logic [5:0]         alu_shift_o,
   output logic [RA_W-1:0]    read_addr_o,
   output logic [RA_W-1:0]    write_addr_o,
   output logic               rf_we_o,
   output logic [1:0]         pc_mux_o,
   output logic               busy_o,
   output logic               illegal_o,
   output logic               bus_err_o
);

   localparam int IMM_W = INSTR_W - OPC_W - 2 * RA_W;
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

`ifdef UC_MEM_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_SHL = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_SHR = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_LD  = OPC_W'(8);
   localparam logic [OPC_W-1:0] OP_ST  = OPC_W'(9);
   localparam logic [OPC_W-1:0] OP_BEQ = OPC_W'(10);
   localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(11);
   localparam logic [OPC_W-1:0] OP_ILL = OPC_W'(12);

   typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

   state_t             state, next_state;
   logic [INSTR_W-1:0] ir;
   logic [CNT_W-1:0]   mem_cnt;
   logic               bus_err_q;

   logic [OPC_W-1:0]   opcode;
   logic [OPC_W-1:0]   opcode_m1;
   logic [RA_W-1:0]    rd, rs;
   logic [IMM_W-1:0]   imm;
   logic [5:0]         shift_val;
   logic               is_alu, is_ld, is_st, is_illegal, timeout;

   assign opcode     = ir[INSTR_W-1 -: OPC_W];
   assign rd         = ir[INSTR_W-OPC_W-1 -: RA_W];
   assign rs         = ir[INSTR_W-OPC_W-RA_W-1 -: RA_W];
   assign imm        = ir[IMM_W-1:0];
   assign shift_val  = 6'(imm);
   assign opcode_m1  = opcode - OPC_W'(1);
   assign is_alu     = (opcode >= OP_ADD) && (opcode <= OP_SHR);
   assign is_ld      = (opcode == OP_LD);
   assign is_st      = (opcode == OP_ST);
   assign is_illegal = (opcode >= OP_ILL);

   // The last MEM cycle without ack expires the access; ack in that same cycle still wins.
   assign timeout    = TIMEOUT_EN && (state == MEM) && (mem_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign bus_err_o  = TIMEOUT_EN ? bus_err_q : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir        <= '0;
         mem_cnt   <= '0;
         bus_err_q <= 1'b0;
      end else begin
         if (state == IDLE && instr_vld_i) ir <= instr_i;
         mem_cnt   <= (state == MEM) ? mem_cnt + CNT_W'(1) : '0;
         bus_err_q <= timeout && !ack_i;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (instr_vld_i) next_state = DECODE;
         DECODE:  next_state = is_illegal ? IDLE : EXEC;
         EXEC: begin
            if (is_alu)               next_state = WB;
            else if (is_ld || is_st)  next_state = MEM;
            else                      next_state = IDLE;
         end
         MEM: begin
            if (ack_i)        next_state = is_ld ? WB : IDLE;
            else if (timeout) next_state = IDLE;
         end
         WB:      next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Ready is masked by rst_n so every output reads 0 while reset is held.
   always_comb begin
      instr_rdy_o   = 1'b0;
      stb_o         = 1'b0;
      mem_we_o      = 1'b0;
      alu_control_o = 3'd0;
      alu_shift_o   = 6'd0;
      read_addr_o   = '0;
      write_addr_o  = '0;
      rf_we_o       = 1'b0;
      pc_mux_o      = 2'd0;
      illegal_o     = 1'b0;
      busy_o        = (state != IDLE);
      case (state)
         IDLE:   instr_rdy_o = rst_n;
         DECODE: begin
            read_addr_o = rs;
            illegal_o   = is_illegal;
         end
         EXEC: begin
            if (is_alu) alu_control_o = opcode_m1[2:0];
            if (opcode == OP_SHL || opcode == OP_SHR) alu_shift_o = shift_val;
            if (opcode == OP_BEQ)      pc_mux_o = zero_i ? 2'd1 : 2'd0;
            else if (opcode == OP_JMP) pc_mux_o = 2'd2;
         end
         MEM: begin
            stb_o    = 1'b1;
            mem_we_o = is_st;
         end
         WB: begin
            rf_we_o      = 1'b1;
            write_addr_o = rd;
         end
         default: ;
      endcase
   end

endmodule
